// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared RV32 register-file types for the writeback arbiter slice.
package rv32_pkg;
    localparam int XLEN = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Core-side bundle of the writeback arbiter: writeback, long-latency return, decode and regfile port.
interface regfile_wb_arbiter_if;
    import rv32_pkg::*;

    logic            wb_valid;
    reg_addr_t       wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            lat_alloc_valid;
    reg_addr_t       lat_alloc_rd;
    logic            lat_alloc_ok;
    logic            lat_valid;
    logic            lat_ready;
    reg_addr_t       lat_rd;
    logic [XLEN-1:0] lat_data;
    reg_addr_t       rs1_addr;
    reg_addr_t       rs2_addr;
    logic            rs1_used;
    logic            rs2_used;
    logic            core_stall;
    logic            reg_we;
    reg_addr_t       rd_addr;
    logic [XLEN-1:0] rd_wdata;

    modport master (
        output wb_valid, wb_rd, wb_data, lat_alloc_valid, lat_alloc_rd,
               lat_valid, lat_rd, lat_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
        input  lat_alloc_ok, lat_ready, core_stall, reg_we, rd_addr, rd_wdata
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, lat_alloc_valid, lat_alloc_rd,
               lat_valid, lat_rd, lat_data, rs1_addr, rs2_addr, rs1_used, rs2_used,
        output lat_alloc_ok, lat_ready, core_stall, reg_we, rd_addr, rd_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO of pending secondary writebacks; storage is not reset, only the pointers.
module wb_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_push,
    input  wb_entry_t i_push_data,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between core writeback (priority) and a buffered
// long-latency return path, with a busy scoreboard driving the core stall.
module regfile_wb_arbiter
    import rv32_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic          r_run;
    logic [31:0]   r_busy;
    logic [WW-1:0] r_wait;
    logic [31:0]   w_busy_nxt;
    wb_entry_t     w_head;
    wb_entry_t     w_push_data;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_alloc_set;
    logic          w_hz;
    logic          w_force;

    function automatic logic rs_hazard(input reg_addr_t rs, input logic used,
                                       input logic [31:0] busy, input logic head_now,
                                       input reg_addr_t head_rd);
        return used & (rs != REG_ZERO) & busy[rs] & ~(head_now & (head_rd == rs));
    endfunction

    assign bus.lat_ready = r_run & ~w_full;
    assign w_push        = bus.lat_valid & bus.lat_ready;
    assign w_push_data   = '{rd: bus.lat_rd, data: bus.lat_data};
    assign w_pop         = r_run & ~bus.wb_valid & ~w_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        bus.reg_we   = 1'b0;
        bus.rd_addr  = REG_ZERO;
        bus.rd_wdata = '0;
        if (r_run && bus.wb_valid) begin
            bus.reg_we   = (bus.wb_rd != REG_ZERO);
            bus.rd_addr  = bus.wb_rd;
            bus.rd_wdata = bus.wb_data;
        end else if (w_pop) begin
            bus.reg_we   = (w_head.rd != REG_ZERO);
            bus.rd_addr  = w_head.rd;
            bus.rd_wdata = w_head.data;
        end
    end

    assign bus.lat_alloc_ok = r_run & ((bus.lat_alloc_rd == REG_ZERO) | ~r_busy[bus.lat_alloc_rd]);
    assign w_alloc_set      = bus.lat_alloc_valid & bus.lat_alloc_ok & (bus.lat_alloc_rd != REG_ZERO);

    // Clear first so a same-cycle reservation of the retiring register survives
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)       w_busy_nxt[w_head.rd]          = 1'b0;
        if (w_alloc_set) w_busy_nxt[bus.lat_alloc_rd]   = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Head exclusion uses FIFO occupancy rather than wb_valid, keeping stall free of a loop through the core
    assign w_hz = rs_hazard(bus.rs1_addr, bus.rs1_used, r_busy, ~w_empty, w_head.rd)
                | rs_hazard(bus.rs2_addr, bus.rs2_used, r_busy, ~w_empty, w_head.rd);
    assign w_force        = (r_wait == WW'(MAX_WAIT));
    assign bus.core_stall = ~r_run | w_hz | w_force;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_busy <= '0;
            r_wait <= '0;
        end else begin
            r_run  <= 1'b1;
            r_busy <= w_busy_nxt;
            if (w_empty || w_pop)
                r_wait <= '0;
            else if (bus.wb_valid && !w_force)
                r_wait <= r_wait + WW'(1);
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model predicts each cycle.
module tb_regfile_wb_arbiter;
    import rv32_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if u_if ();

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct { bit stall; bit ready; bit ok; bit we; } ctrl_t;
    typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;

    ctrl_t     cq[$];
    wr_t       wq[$];
    wb_entry_t mq[$];
    bit        mbusy [32];
    int        mwait;
    bit        mrun;
    int        checks   = 0;
    int        failures = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit mhz(logic [4:0] rs, logic used);
        return used && rs != 0 && mbusy[rs] && !(mq.size() > 0 && mq[0].rd == rs);
    endfunction

    task automatic set_in(bit wv, logic [4:0] wrd, logic [31:0] wd,
                          bit lv, logic [4:0] lrd, logic [31:0] ld,
                          bit av, logic [4:0] ard,
                          logic [4:0] r1, bit u1, logic [4:0] r2, bit u2);
        u_if.wb_valid = wv; u_if.wb_rd = wrd; u_if.wb_data = wd;
        u_if.lat_valid = lv; u_if.lat_rd = lrd; u_if.lat_data = ld;
        u_if.lat_alloc_valid = av; u_if.lat_alloc_rd = ard;
        u_if.rs1_addr = r1; u_if.rs1_used = u1; u_if.rs2_addr = r2; u_if.rs2_used = u2;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_clear();
        mq.delete();
        foreach (mbusy[i]) mbusy[i] = 0;
        mwait = 0;
        mrun  = 0;
    endtask

    // Called just after a rising edge: predicts this cycle, then advances the model at the next edge
    task automatic step();
        ctrl_t c;
        wr_t   w;
        bit    pop;
        c.ready = mrun && mq.size() < DEPTH;
        c.ok    = mrun && (u_if.lat_alloc_rd == 0 || !mbusy[u_if.lat_alloc_rd]);
        c.stall = !mrun || mhz(u_if.rs1_addr, u_if.rs1_used) || mhz(u_if.rs2_addr, u_if.rs2_used)
                  || mwait == MAXW;
        c.we = 0;
        pop  = 0;
        w    = '{a: 0, d: 0};
        if (mrun && u_if.wb_valid) begin
            if (u_if.wb_rd != 0) begin c.we = 1; w = '{a: u_if.wb_rd, d: u_if.wb_data}; end
        end else if (mrun && mq.size() > 0) begin
            pop = 1;
            if (mq[0].rd != 0) begin c.we = 1; w = '{a: mq[0].rd, d: mq[0].data}; end
        end
        cq.push_back(c);
        if (c.we) wq.push_back(w);
        @(posedge clk);
        if (rst_n) begin
            if (mq.size() == 0 || pop) mwait = 0;
            else if (u_if.wb_valid && mwait < MAXW) mwait++;
            if (pop) begin
                mbusy[mq[0].rd] = 0;
                void'(mq.pop_front());
            end
            if (u_if.lat_alloc_valid && c.ok && u_if.lat_alloc_rd != 0) mbusy[u_if.lat_alloc_rd] = 1;
            if (u_if.lat_valid && c.ready) mq.push_back('{rd: u_if.lat_rd, data: u_if.lat_data});
            mrun = 1;
        end
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_clear();
        step();
        rst_n = 1'b1;
        step();
    endtask

    always @(negedge clk) begin : monitor
        ctrl_t c;
        wr_t   w;
        if (cq.size() > 0) begin
            c = cq.pop_front();
            chk("core_stall",   32'(u_if.core_stall),   32'(c.stall));
            chk("lat_ready",    32'(u_if.lat_ready),    32'(c.ready));
            chk("lat_alloc_ok", 32'(u_if.lat_alloc_ok), 32'(c.ok));
            chk("reg_we",       32'(u_if.reg_we),       32'(c.we));
            if (u_if.reg_we) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=x%0d required=none", u_if.rd_addr);
                end else begin
                    w = wq.pop_front();
                    chk("rd_addr",  32'(u_if.rd_addr), 32'(w.a));
                    chk("rd_wdata", u_if.rd_wdata,     w.d);
                end
            end else if (c.we && wq.size() > 0) begin
                void'(wq.pop_front());
            end
        end
    end

    initial begin
        model_clear();
        idle();
        repeat (2) @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        step();

        // Single secondary write drains the next cycle
        set_in(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0); step();
        idle(); step(); step();

        // Primary wins; secondary waits for an idle writeback slot
        set_in(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0, 0); step();
        idle(); step(); step();

        // Reservation, RAW stall, forwarding cycle, re-reservation
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 7, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0); step(); step();
        set_in(0, 0, 0, 1, 7, 32'h7777, 0, 0, 7, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 7, 1); step();
        idle(); step();
        set_in(0, 0, 0, 1, 7, 32'h7070, 0, 0, 0, 0, 0, 0); step();
        idle(); step();

        // Starvation: one buffered entry blocked by continuous writebacks
        set_in(1, 1, 32'hA0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0); step();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 2, 32'hB0 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        end
        idle(); step(); step();

        // Fill past capacity, with x0 entries
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_in(1, 6, 32'hC0 + i, 1, (i % 2 == 0) ? 5'd0 : 5'(10 + i), 32'hE0 + i, 0, 0, 0, 0, 0, 0);
            step();
        end
        idle();
        for (int i = 0; i < DEPTH + 2; i++) step();

        // Reset mid-fill discards buffered writes and reservations
        set_in(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 6, 32'h600 + i, 1, 5'(12 + i), 32'h700 + i, 0, 0, 0, 0, 0, 0); step();
        end
        idle();
        reset_pulse();
        set_in(0, 0, 0, 0, 0, 0, 1, 12, 12, 1, 0, 0); step();
        idle(); step(); step();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bit wv;
            wv = ($urandom_range(0, 99) < ((n / 100) % 2 == 0 ? 40 : 85));
            set_in(wv, 5'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
                   ($urandom_range(0, 99) < 25), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 199) == 0) reset_pulse();
            else step();
        end

        idle();
        for (int i = 0; i < DEPTH + 2; i++) step();
        @(negedge clk);
        #1;
        chk("pending_writes", 32'(wq.size()), 32'd0);
        chk("pending_ctrl",   32'(cq.size()), 32'd0);
        chk("model_fifo_drained", 32'(mq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
